// File: rtl/mru_pkg.sv
// mru_pkg: shared types and helpers for the MRU/LRU recency tracker.
//   policy_e    - replacement policy selector (evict most or least recent)
//   onehot_t    - result of onehot_idx: valid flag plus index of the set bit
//   is_onehot   - true when exactly one bit of a (zero-extended) vector is set
//   onehot_idx  - index of the set bit, valid only for a one-hot vector
//   STAT_W      - width of the optional hit/miss statistics counters
package mru_pkg;

    localparam int unsigned STAT_W    = 16;
    localparam int unsigned VEC_W     = 32;
    localparam int unsigned VEC_IDX_W = 5;

    typedef enum logic {
        POL_MRU = 1'b0,
        POL_LRU = 1'b1
    } policy_e;

    typedef struct packed {
        logic                 vld;
        logic [VEC_IDX_W-1:0] idx;
    } onehot_t;

    // v & (v-1) clears the lowest set bit; zero afterwards means at most one bit
    function automatic logic is_onehot(input logic [VEC_W-1:0] v);
        return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
    endfunction

    function automatic onehot_t onehot_idx(input logic [VEC_W-1:0] v);
        onehot_t r;
        r.vld = is_onehot(v);
        r.idx = '0;
        for (int i = 0; i < int'(VEC_W); i++) begin
            if (v[i]) r.idx = VEC_IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/mru_stack.sv
// mru_stack: recency stack of DEPTH slots (slot 0 = most recent) with
// lookup, shift/insert and eviction, plus a registered residency mask.
//   clk, rst     - clock, synchronous active-high reset
//   acc          - accepted access this cycle (one-hot request on tick)
//   ch           - channel index of the access
//   policy       - victim choice when full: POL_MRU = slot 0, POL_LRU = slot DEPTH-1
//   resident     - registered bit-per-channel residency mask
//   occupancy    - registered number of valid slots
//   hit_c        - ch is currently resident
//   evict_c      - a miss on a full stack would displace an entry
//   evict_idx_c  - channel that would be displaced
module mru_stack
    import mru_pkg::*;
#(
    parameter int unsigned N_CH  = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             acc,
    input  logic [$clog2(N_CH)-1:0]          ch,
    input  policy_e                          policy,
    output logic [N_CH-1:0]                  resident,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy,
    output logic                             hit_c,
    output logic                             evict_c,
    output logic [$clog2(N_CH)-1:0]          evict_idx_c
);

    localparam int unsigned IDX_W = $clog2(N_CH);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [IDX_W-1:0] slot_q   [DEPTH];
    logic [IDX_W-1:0] slot_nxt [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] at_or_above_hit;
    logic             full;
    logic             shift_all;
    logic             seen;
    logic [OCC_W-1:0] occ_nxt;
    logic [N_CH-1:0]  res_nxt;

    // Lookup and next-state computation for the slot array
    always_comb begin
        valid           = '0;
        match           = '0;
        at_or_above_hit = '0;
        seen            = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            valid[i] = OCC_W'(i) < occupancy;
            match[i] = valid[i] && (slot_q[i] == ch);
        end
        // at_or_above_hit[i]: the hit slot is at position >= i, so slot i shifts
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            seen               = seen | match[i];
            at_or_above_hit[i] = seen;
        end
        hit_c       = at_or_above_hit[0];
        full        = (occupancy == OCC_W'(DEPTH));
        evict_c     = !hit_c && full;
        evict_idx_c = (policy == POL_LRU) ? slot_q[DEPTH-1] : slot_q[0];
        // MRU eviction on a full stack overwrites slot 0 in place
        shift_all   = !hit_c && !(full && (policy == POL_MRU));

        slot_nxt[0] = ch;
        for (int i = 1; i < int'(DEPTH); i++) begin
            slot_nxt[i] = (hit_c ? at_or_above_hit[i] : shift_all) ? slot_q[i-1] : slot_q[i];
        end

        occ_nxt = occupancy;
        if (!hit_c && !full) occ_nxt = occupancy + OCC_W'(1);

        res_nxt = resident;
        if (evict_c) res_nxt[evict_idx_c] = 1'b0;
        res_nxt[ch] = 1'b1;
    end

    // Slot array, occupancy and residency mask registers
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
            resident  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
        end else if (acc) begin
            occupancy <= occ_nxt;
            resident  <= res_nxt;
            for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= slot_nxt[i];
        end
    end

endmodule

// File: rtl/mru_tracker.sv
// mru_tracker: recency tracker for N_CH one-hot request channels holding up
// to DEPTH resident channels, with run-time MRU/LRU replacement.
//   clk, rst             - clock, synchronous active-high reset (wins over tick)
//   tick                 - sample enable, one cycle wide
//   req                  - request lines, bit i = channel i
//   policy               - 0 = evict MRU, 1 = evict LRU (sampled with tick)
//   led                  - bit i high while channel i is resident
//   hit, miss            - pulse: accepted request resident / not resident
//   evict_vld, evict_idx - pulse and index of a displaced channel
//   req_err              - pulse: tick with more than one req bit set
//   occupancy            - number of resident entries
//   hit_count, miss_count- saturating statistics, built only with MRU_STATS_EN
//                          defined; tied to 0 otherwise
module mru_tracker
    import mru_pkg::*;
#(
    parameter int unsigned N_CH  = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [N_CH-1:0]             req,
    input  logic                        policy,
    output logic [N_CH-1:0]             led,
    output logic                        hit,
    output logic                        miss,
    output logic                        evict_vld,
    output logic [$clog2(N_CH)-1:0]     evict_idx,
    output logic                        req_err,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy,
    output logic [STAT_W-1:0]           hit_count,
    output logic [STAT_W-1:0]           miss_count
);

    localparam int unsigned IDX_W = $clog2(N_CH);

    onehot_t          oh_c;
    logic             acc_c;
    logic             req_err_c;
    logic [IDX_W-1:0] ch_c;
    logic             hit_c;
    logic             evict_c;
    logic [IDX_W-1:0] evict_idx_c;

    // Request qualification; tick gates everything so X on idle req is harmless
    always_comb begin
        oh_c      = onehot_idx(VEC_W'(req));
        acc_c     = tick && oh_c.vld;
        req_err_c = tick && (req != '0) && !oh_c.vld;
        ch_c      = IDX_W'(oh_c.idx);
    end

    mru_stack #(
        .N_CH  (N_CH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .acc         (acc_c),
        .ch          (ch_c),
        .policy      (policy_e'(policy)),
        .resident    (led),
        .occupancy   (occupancy),
        .hit_c       (hit_c),
        .evict_c     (evict_c),
        .evict_idx_c (evict_idx_c)
    );

    // Single-cycle status pulses; evict_idx holds the last victim
    always_ff @(posedge clk) begin
        if (rst) begin
            hit       <= 1'b0;
            miss      <= 1'b0;
            evict_vld <= 1'b0;
            evict_idx <= '0;
            req_err   <= 1'b0;
        end else begin
            hit       <= acc_c && hit_c;
            miss      <= acc_c && !hit_c;
            evict_vld <= acc_c && evict_c;
            req_err   <= req_err_c;
            if (acc_c && evict_c) evict_idx <= evict_idx_c;
        end
    end

`ifdef MRU_STATS_EN
    // Saturating counters advanced by the outgoing pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != '1))   hit_count  <= hit_count + STAT_W'(1);
            if (miss && (miss_count != '1)) miss_count <= miss_count + STAT_W'(1);
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_mru_tracker.sv
// tb_mru_tracker: directed checks of mru_tracker (N_CH=5, DEPTH=4) and a
// second instance with DEPTH=3 for the shallow-stack LRU case.
module tb_mru_tracker;
    import mru_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: N_CH=5, DEPTH=4
    logic        rst, tick, policy;
    logic [4:0]  req;
    logic [4:0]  led;
    logic        hit, miss, evict_vld, req_err;
    logic [2:0]  evict_idx;
    logic [2:0]  occupancy;
    logic [15:0] hit_count, miss_count;

    // Second instance: N_CH=5, DEPTH=3
    logic        rst3, tick3, policy3;
    logic [4:0]  req3;
    logic [4:0]  led3;
    logic        hit3, miss3, evict_vld3, req_err3;
    logic [2:0]  evict_idx3;
    logic [1:0]  occupancy3;
    logic [15:0] hit_count3, miss_count3;

    int n_pass  = 0;
    int n_total = 0;

    mru_tracker #(.N_CH(5), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .policy(policy),
        .led(led), .hit(hit), .miss(miss), .evict_vld(evict_vld),
        .evict_idx(evict_idx), .req_err(req_err), .occupancy(occupancy),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    mru_tracker #(.N_CH(5), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst3), .tick(tick3), .req(req3), .policy(policy3),
        .led(led3), .hit(hit3), .miss(miss3), .evict_vld(evict_vld3),
        .evict_idx(evict_idx3), .req_err(req_err3), .occupancy(occupancy3),
        .hit_count(hit_count3), .miss_count(miss_count3)
    );

    // Stimulus: one accepted-tick cycle; returns at the negedge after sampling
    task automatic do_tick(input logic [4:0] r);
        @(negedge clk); tick = 1'b1; req = r;
        @(negedge clk); tick = 1'b0; req = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1; tick = 1'b0; req = '0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if (led !== 5'b0) $display("FAIL reset_led: got %b want 00000", led);
        else n_pass++;
        n_total++;
        if (occupancy !== 3'd0) $display("FAIL reset_occ: got %0d want 0", occupancy);
        else n_pass++;
        n_total++;
        if ({hit, miss, evict_vld, req_err, evict_idx} !== 7'b0)
            $display("FAIL reset_pulses: got %b want 0000000", {hit, miss, evict_vld, req_err, evict_idx});
        else n_pass++;
        n_total++;
        if ({hit_count, miss_count} !== 32'h0)
            $display("FAIL reset_counters: got %h want 00000000", {hit_count, miss_count});
        else n_pass++;
    endtask

    // Fill sequence ending in a forced eviction under the given policy
    task automatic test_sequence(input logic pol);
        logic [4:0] seq_req [12];
        logic [4:0] seq_led [12];
        logic       seq_hit [12];
        logic [4:0] exp_led;
        logic [7:0] got, expv;
        seq_req = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd4, 5'd4, 5'd4, 5'd8, 5'd8, 5'd16};
        seq_led = '{5'd1, 5'd1, 5'd1, 5'd3, 5'd3, 5'd3, 5'd7, 5'd7, 5'd7, 5'd15, 5'd15, 5'd0};
        seq_hit = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        policy = pol;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            do_tick(seq_req[k]);
            exp_led = (k == 11) ? (pol ? 5'b11110 : 5'b10111) : seq_led[k];
            got  = {led, hit, miss, evict_vld};
            expv = {exp_led, seq_hit[k], !seq_hit[k], (k == 11)};
            n_total++;
            if (got !== expv)
                $display("FAIL seq_pol%0d_step%0d: {led,hit,miss,evict} got %b want %b", pol, k, got, expv);
            else n_pass++;
        end
        n_total++;
        if (evict_idx !== (pol ? 3'd0 : 3'd3))
            $display("FAIL seq_pol%0d_evict_idx: got %0d want %0d", pol, evict_idx, pol ? 0 : 3);
        else n_pass++;
        n_total++;
        if (occupancy !== 3'd4) $display("FAIL seq_pol%0d_occ: got %0d want 4", pol, occupancy);
        else n_pass++;
    endtask

    task automatic test_req_err();
        policy = 1'b0;
        apply_reset();
        do_tick(5'b00001);
        do_tick(5'b00010);
        do_tick(5'b00101);
        n_total++;
        if ({led, req_err, hit, miss} !== {5'b00011, 3'b100})
            $display("FAIL req_err_pulse: {led,err,hit,miss} got %b want 00011100", {led, req_err, hit, miss});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (req_err !== 1'b0) $display("FAIL req_err_width: got %b want 0", req_err);
        else n_pass++;
        do_tick(5'b00000);
        n_total++;
        if ({led, req_err, hit, miss, evict_vld} !== {5'b00011, 4'b0000})
            $display("FAIL zero_req: {led,err,hit,miss,evict} got %b want 000110000", {led, req_err, hit, miss, evict_vld});
        else n_pass++;
        // X on req while tick is low must not disturb anything
        @(negedge clk); tick = 1'b0; req = 'x;
        @(negedge clk); req = '0;
        n_total++;
        if ({led, occupancy, req_err, hit, miss} !== {5'b00011, 3'd2, 3'b000})
            $display("FAIL idle_x_req: {led,occ,err,hit,miss} got %b want 00011010000", {led, occupancy, req_err, hit, miss});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        policy = 1'b0;
        apply_reset();
        @(negedge clk); tick = 1'b1; req = 5'b00001;
        @(negedge clk);
        n_total++;
        if ({led, hit, miss} !== {5'b00001, 2'b01})
            $display("FAIL b2b_0: {led,hit,miss} got %b want 0000101", {led, hit, miss});
        else n_pass++;
        req = 5'b00010;
        @(negedge clk);
        n_total++;
        if ({led, hit, miss} !== {5'b00011, 2'b01})
            $display("FAIL b2b_1: {led,hit,miss} got %b want 0001101", {led, hit, miss});
        else n_pass++;
        req = 5'b00001;
        @(negedge clk);
        n_total++;
        if ({led, hit, miss, occupancy} !== {5'b00011, 2'b10, 3'd2})
            $display("FAIL b2b_2: {led,hit,miss,occ} got %b want 0001110010", {led, hit, miss, occupancy});
        else n_pass++;
        tick = 1'b0; req = '0;
        @(negedge clk);
        n_total++;
        if ({hit, miss} !== 2'b00) $display("FAIL b2b_idle: {hit,miss} got %b want 00", {hit, miss});
        else n_pass++;
    endtask

    task automatic test_depth3();
        logic [4:0] seq [5];
        seq = '{5'b00001, 5'b00010, 5'b00100, 5'b00001, 5'b10000};
        @(negedge clk); rst3 = 1'b1;
        @(negedge clk); rst3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            policy3 = (k == 4);
            @(negedge clk); tick3 = 1'b1; req3 = seq[k];
            @(negedge clk); tick3 = 1'b0; req3 = '0;
            if (k == 3) begin
                n_total++;
                if ({led3, hit3, miss3} !== {5'b00111, 2'b10})
                    $display("FAIL d3_hit: {led,hit,miss} got %b want 0011110", {led3, hit3, miss3});
                else n_pass++;
            end
        end
        n_total++;
        if ({led3, evict_vld3, miss3} !== {5'b10101, 2'b11})
            $display("FAIL d3_evict: {led,evict,miss} got %b want 1010111", {led3, evict_vld3, miss3});
        else n_pass++;
        n_total++;
        if (evict_idx3 !== 3'd1) $display("FAIL d3_evict_idx: got %0d want 1", evict_idx3);
        else n_pass++;
        n_total++;
        if (occupancy3 !== 2'd3) $display("FAIL d3_occ: got %0d want 3", occupancy3);
        else n_pass++;
    endtask

    task automatic test_rst_tick();
        policy = 1'b0;
        apply_reset();
        do_tick(5'b00001);
        do_tick(5'b00010);
        do_tick(5'b00100);
        do_tick(5'b01000);
        n_total++;
        if (led !== 5'b01111) $display("FAIL rst_tick_pre: led got %b want 01111", led);
        else n_pass++;
        @(negedge clk); rst = 1'b1; tick = 1'b1; req = 5'b10000;
        @(negedge clk); rst = 1'b0; tick = 1'b0; req = '0;
        n_total++;
        if ({led, occupancy} !== 8'b0)
            $display("FAIL rst_tick_state: {led,occ} got %b want 00000000", {led, occupancy});
        else n_pass++;
        n_total++;
        if ({hit, miss, evict_vld, req_err} !== 4'b0)
            $display("FAIL rst_tick_pulses: got %b want 0000", {hit, miss, evict_vld, req_err});
        else n_pass++;
        n_total++;
        if ({hit_count, miss_count} !== 32'h0)
            $display("FAIL rst_tick_counters: got %h want 00000000", {hit_count, miss_count});
        else n_pass++;
    endtask

    task automatic test_stats();
        logic [15:0] exp_hits, exp_misses;
`ifdef MRU_STATS_EN
        exp_hits = 16'd5; exp_misses = 16'd3;
`else
        exp_hits = 16'd0; exp_misses = 16'd0;
`endif
        policy = 1'b0;
        apply_reset();
        do_tick(5'b00001);   // miss
        do_tick(5'b00001);   // hit
        do_tick(5'b00010);   // miss
        do_tick(5'b00010);   // hit
        do_tick(5'b00001);   // hit
        do_tick(5'b00100);   // miss
        do_tick(5'b00100);   // hit
        do_tick(5'b00010);   // hit
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (hit_count !== exp_hits) $display("FAIL stats_hits: got %0d want %0d", hit_count, exp_hits);
        else n_pass++;
        n_total++;
        if (miss_count !== exp_misses) $display("FAIL stats_misses: got %0d want %0d", miss_count, exp_misses);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; req = '0; policy = 1'b0;
        rst3 = 1'b1; tick3 = 1'b0; req3 = '0; policy3 = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_sequence(1'b0);
        test_sequence(1'b1);
        test_req_err();
        test_back_to_back();
        test_depth3();
        test_rst_tick();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
